gray_packer: RTL and testbench

GRAY_PACKER -- requirements
Module: gray_packer

---
 rtl/gray_packer.sv | 153 +++++++++++++++
 tb/tb_gray_packer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/gray_packer.sv
// -----------------------------------------------------------------------------
// gray_packer
//
// Packs 8-bit grayscale pixels, four per 32-bit word (pixel 0 in bits 7:0),
// and queues the words in a small FIFO for a downstream consumer. A word is
// closed early when a pixel carries endOfLine; its unfilled lanes are zero and
// byteEnables marks only the lanes that hold pixels.
//
// Optional feature:
//   GRAY_PACKER_SATURATE_EN  - when defined, a grayIn above 255 becomes 8'hFF;
//                              otherwise the pixel byte is grayIn[7:0].
//
// Ports:
//   clock        in   1   single clock, rising edge
//   nReset       in   1   asynchronous active-low reset
//   pixelValid   in   1   grayIn holds a valid sample
//   grayIn       in   32  grayscale sum from the converter
//   endOfLine    in   1   current pixel is the last of its line
//   pixelReady   out  1   pixel is accepted this cycle (FIFO not full)
//   wordValid    out  1   wordData/byteEnables hold the FIFO head word
//   wordReady    in   1   consumer takes the head word this cycle
//   wordData     out  32  packed grayscale word
//   byteEnables  out  4   valid byte lanes of wordData
//   wordCount    out  16  words popped since reset (wraps)
// -----------------------------------------------------------------------------
module gray_packer #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clock,
    input  logic        nReset,
    input  logic        pixelValid,
    input  logic [31:0] grayIn,
    input  logic        endOfLine,
    output logic        pixelReady,
    output logic        wordValid,
    input  logic        wordReady,
    output logic [31:0] wordData,
    output logic [3:0]  byteEnables,
    output logic [15:0] wordCount
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    // Pixel byte formation: truncation or clamp depending on build.
    function automatic logic [7:0] pix_byte(input logic [31:0] g);
`ifdef GRAY_PACKER_SATURATE_EN
        pix_byte = (g > 32'd255) ? 8'hFF : g[7:0];
`else
        pix_byte = g[7:0];
`endif
    endfunction

    // Lanes 0..l are filled when the word closes at lane l.
    function automatic logic [3:0] lane_mask(input logic [1:0] l);
        case (l)
            2'd0:    lane_mask = 4'b0001;
            2'd1:    lane_mask = 4'b0011;
            2'd2:    lane_mask = 4'b0111;
            default: lane_mask = 4'b1111;
        endcase
    endfunction

    // Packing state
    logic [1:0]  lane_q, lane_d;
    logic [31:0] part_q, part_d;
    logic [31:0] push_word;
    logic        accept, push, pop, full;

    // FIFO state
    logic [31:0]      mem_q [FIFO_DEPTH];
    logic [3:0]       be_q  [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [15:0]      wcount_q, wcount_d;

    assign full       = (count_q == CNT_W'(FIFO_DEPTH));
    assign pixelReady = ~full;
    assign wordValid  = (count_q != '0);
    assign accept     = pixelValid & pixelReady;
    assign pop        = wordValid & wordReady;

    // Outputs read zero while the FIFO is empty so storage needs no reset.
    assign wordData    = wordValid ? mem_q[rd_ptr_q] : 32'd0;
    assign byteEnables = wordValid ? be_q[rd_ptr_q]  : 4'd0;
    assign wordCount   = wcount_q;

    // Lane packing: the partial word keeps unfilled lanes at zero, so the
    // pushed word is the partial word with the current byte merged in.
    always_comb begin
        lane_d    = lane_q;
        part_d    = part_q;
        push      = 1'b0;
        push_word = part_q;
        push_word[{lane_q, 3'b000} +: 8] = pix_byte(grayIn);
        if (accept) begin
            if (lane_q == 2'd3 || endOfLine) begin
                push   = 1'b1;
                lane_d = 2'd0;
                part_d = 32'd0;
            end else begin
                lane_d = lane_q + 2'd1;
                part_d = push_word;
            end
        end
    end

    // FIFO pointers and occupancy; push and pop together leave count as is.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        wcount_d = wcount_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            wcount_d = wcount_q + 16'd1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            lane_q   <= 2'd0;
            part_q   <= 32'd0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            wcount_q <= 16'd0;
        end else begin
            lane_q   <= lane_d;
            part_q   <= part_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            wcount_q <= wcount_d;
        end
    end

    // Word storage; only reachable through the occupancy-gated outputs.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_word;
            be_q[wr_ptr_q]  <= lane_mask(lane_q);
        end
    end

endmodule

// File: tb/tb_gray_packer.sv
module tb_gray_packer;

    logic        clock = 1'b0;
    logic        nReset;
    logic        pixelValid;
    logic [31:0] grayIn;
    logic        endOfLine;
    logic        pixelReady;
    logic        wordValid;
    logic        wordReady;
    logic [31:0] wordData;
    logic [3:0]  byteEnables;
    logic [15:0] wordCount;

    int total = 0;
    int bad   = 0;

    gray_packer #(.FIFO_DEPTH(4)) dut (
        .clock       (clock),
        .nReset      (nReset),
        .pixelValid  (pixelValid),
        .grayIn      (grayIn),
        .endOfLine   (endOfLine),
        .pixelReady  (pixelReady),
        .wordValid   (wordValid),
        .wordReady   (wordReady),
        .wordData    (wordData),
        .byteEnables (byteEnables),
        .wordCount   (wordCount)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // One pixel offered for one cycle; returns #1 after the edge.
    task automatic pix(input logic [31:0] v, input logic eol, input logic rdy);
        @(negedge clock);
        pixelValid = 1'b1;
        grayIn     = v;
        endOfLine  = eol;
        wordReady  = rdy;
        @(posedge clock);
        #1;
        pixelValid = 1'b0;
        endOfLine  = 1'b0;
        wordReady  = 1'b0;
    endtask

    task automatic pop_one;
        @(negedge clock);
        wordReady = 1'b1;
        @(posedge clock);
        #1;
        wordReady = 1'b0;
    endtask

    logic [7:0] sat_exp;
    int         acc;
    logic [7:0] nxt;

    initial begin
        nReset     = 1'b0;
        pixelValid = 1'b0;
        grayIn     = 32'd0;
        endOfLine  = 1'b0;
        wordReady  = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        nReset = 1'b1;
        #1;
        chk("rst_wordValid", {31'd0, wordValid}, 32'd0);
        chk("rst_wordData", wordData, 32'd0);
        chk("rst_byteEn", {28'd0, byteEnables}, 32'd0);
        chk("rst_pixelReady", {31'd0, pixelReady}, 32'd1);
        chk("rst_wordCount", {16'd0, wordCount}, 32'd0);

        // Full word, one-cycle latency
        pix(32'h10, 1'b0, 1'b0);
        pix(32'h20, 1'b0, 1'b0);
        pix(32'h30, 1'b0, 1'b0);
        chk("w1_not_yet", {31'd0, wordValid}, 32'd0);
        pix(32'h40, 1'b0, 1'b0);
        chk("w1_valid", {31'd0, wordValid}, 32'd1);
        chk("w1_data", wordData, 32'h40302010);
        chk("w1_be", {28'd0, byteEnables}, 32'hF);
        pop_one();
        chk("w1_popped", {31'd0, wordValid}, 32'd0);
        chk("w1_count", {16'd0, wordCount}, 32'd1);

        // End-of-line closes a partial word
        pix(32'hAA, 1'b0, 1'b0);
        pix(32'hBB, 1'b1, 1'b0);
        chk("eol_data", wordData, 32'h0000BBAA);
        chk("eol_be", {28'd0, byteEnables}, 32'h3);
        pop_one();
        pix(32'h55, 1'b1, 1'b0);
        chk("lane0_data", wordData, 32'h00000055);
        chk("lane0_be", {28'd0, byteEnables}, 32'h1);
        pop_one();

        // endOfLine without pixelValid does nothing
        @(negedge clock);
        endOfLine = 1'b1;
        @(posedge clock);
        #1;
        endOfLine = 1'b0;
        chk("eol_ignored", {31'd0, wordValid}, 32'd0);

        // Byte formation of an over-range sum
`ifdef GRAY_PACKER_SATURATE_EN
        sat_exp = 8'hFF;
`else
        sat_exp = 8'h2C;
`endif
        pix(32'h12C, 1'b1, 1'b0);
        chk("sat_data", wordData, {24'd0, sat_exp});
        pop_one();
        chk("count4", {16'd0, wordCount}, 32'd4);

        // Backpressure: 20 pixels offered, 16 fit in 4 words
        acc = 0;
        nxt = 8'd1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            pixelValid = 1'b1;
            grayIn     = {24'd0, nxt};
            if (pixelReady) begin
                acc++;
                nxt = nxt + 8'd1;
            end
            @(posedge clock);
        end
        #1;
        pixelValid = 1'b0;
        chk("bp_accepted", acc, 32'd16);
        chk("bp_ready_low", {31'd0, pixelReady}, 32'd0);
        chk("bp_head_stable", wordData, 32'h04030201);
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            chk("drain_valid", {31'd0, wordValid}, 32'd1);
            chk("drain_data", wordData,
                {8'(4*k+4), 8'(4*k+3), 8'(4*k+2), 8'(4*k+1)});
            wordReady = 1'b1;
            @(posedge clock);
        end
        #1;
        wordReady = 1'b0;
        chk("drain_empty", {31'd0, wordValid}, 32'd0);
        chk("drain_count", {16'd0, wordCount}, 32'd8);

        // Reset mid-operation: two words queued, three pixels in progress
        for (int i = 0; i < 11; i++) pix(32'h60 + i, 1'b0, 1'b0);
        chk("pre_rst_valid", {31'd0, wordValid}, 32'd1);
        @(negedge clock);
        nReset = 1'b0;
        #1;
        chk("async_rst_valid", {31'd0, wordValid}, 32'd0);
        chk("async_rst_count", {16'd0, wordCount}, 32'd0);
        @(negedge clock);
        nReset = 1'b1;
        #1;
        chk("post_rst_ready", {31'd0, pixelReady}, 32'd1);
        pix(32'hD1, 1'b0, 1'b0);
        pix(32'hD2, 1'b0, 1'b0);
        pix(32'hD3, 1'b0, 1'b0);
        pix(32'hD4, 1'b0, 1'b0);
        chk("fresh_data", wordData, 32'hD4D3D2D1);
        chk("fresh_be", {28'd0, byteEnables}, 32'hF);

        // Push and pop on the same edge
        pix(32'hE1, 1'b0, 1'b0);
        pix(32'hE2, 1'b0, 1'b0);
        pix(32'hE3, 1'b0, 1'b0);
        pix(32'hE4, 1'b0, 1'b1);
        chk("pp_valid", {31'd0, wordValid}, 32'd1);
        chk("pp_data", wordData, 32'hE4E3E2E1);
        chk("pp_count", {16'd0, wordCount}, 32'd1);
        pop_one();
        chk("pp_empty", {31'd0, wordValid}, 32'd0);
        chk("pp_count2", {16'd0, wordCount}, 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
